afifo_rd_packer: RTL and testbench

- Read-side consumer of the async FIFO (afifo); lives entirely in the rclk domain.
- Pops DSIZE-bit entries from the FIFO read port and packs PACK consecutive entries into one wide word.
- Presents each word on a valid/ready output stream, with a flush that emits a partial word.
- Provides full-rate draining (one pop per rclk when data is available) with backpressure toward the FIFO.

---
 rtl/afifo_rd_packer_if.sv | 24 ++
 rtl/afifo_rd_packer.sv | 85 ++++++++
 tb/tb_afifo_rd_packer.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/afifo_rd_packer_if.sv
// afifo_rd_packer_if: FIFO read port and packed-word output stream of the read-side packer
interface afifo_rd_packer_if #(
    parameter int DSIZE = 8,
    parameter int PACK  = 4
);
    localparam int BW = $clog2(PACK + 1);
    logic [DSIZE-1:0]      fifo_rdata;
    logic                  fifo_rempty;
    logic                  fifo_rinc;
    logic                  flush;
    logic [DSIZE*PACK-1:0] out_data;
    logic [BW-1:0]         out_bytes;
    logic                  out_valid;
    logic                  out_ready;
    logic                  busy;
    modport master (
        input  fifo_rdata, fifo_rempty, flush, out_ready,
        output fifo_rinc, out_data, out_bytes, out_valid, busy
    );
    modport slave (
        output fifo_rdata, fifo_rempty, flush, out_ready,
        input  fifo_rinc, out_data, out_bytes, out_valid, busy
    );
endinterface

// File: rtl/afifo_rd_packer.sv
// afifo_rd_packer: drains the async FIFO read port and packs PACK entries per output word
module afifo_rd_packer #(
    parameter int DSIZE = 8,
    parameter int PACK  = 4
) (
    input logic              rclk,
    input logic              rrst,
    afifo_rd_packer_if.master bus
);
    localparam int CW = $clog2(PACK);
    localparam int BW = $clog2(PACK + 1);
    localparam int AW = (PACK - 1) * DSIZE;
    localparam logic [CW-1:0] LAST = CW'(PACK - 1);

    logic [CW-1:0]         cnt_q, cnt_d;
    logic [AW-1:0]         acc_q, acc_d;
    logic [DSIZE*PACK-1:0] out_data_q, out_data_d;
    logic [BW-1:0]         out_bytes_q, out_bytes_d;
    logic                  out_valid_q, out_valid_d;
    logic                  flush_pending_q, flush_pending_d;
    logic                  out_can_load;
    logic                  pop;

    // Pop gating, lane accumulation, word/flush emission and output handshake
    always_comb begin
        out_can_load    = !out_valid_q || bus.out_ready;
        pop             = !rrst && !bus.fifo_rempty && !flush_pending_q && (cnt_q != LAST || out_can_load);
        cnt_d           = cnt_q;
        acc_d           = acc_q;
        out_data_d      = out_data_q;
        out_bytes_d     = out_bytes_q;
        out_valid_d     = out_valid_q;
        flush_pending_d = flush_pending_q;
        if (out_valid_q && bus.out_ready)
            out_valid_d = 1'b0;
        if (flush_pending_q) begin
            if (out_can_load) begin
                out_data_d      = {{DSIZE{1'b0}}, acc_q};
                out_bytes_d     = BW'(cnt_q);
                out_valid_d     = 1'b1;
                cnt_d           = '0;
                acc_d           = '0;
                flush_pending_d = 1'b0;
            end
        end else if (pop) begin
            if (cnt_q == LAST) begin
                out_data_d  = {bus.fifo_rdata, acc_q};
                out_bytes_d = BW'(PACK);
                out_valid_d = 1'b1;
                cnt_d       = '0;
                acc_d       = '0;
            end else begin
                acc_d[int'(cnt_q)*DSIZE +: DSIZE] = bus.fifo_rdata;
                cnt_d = cnt_q + 1'b1;
            end
        end
        if (bus.flush && !flush_pending_q)
            flush_pending_d = (cnt_d != '0);
    end

    // State register with synchronous reset discarding any partial or held word
    always_ff @(posedge rclk) begin
        if (rrst) begin
            cnt_q           <= '0;
            acc_q           <= '0;
            out_data_q      <= '0;
            out_bytes_q     <= '0;
            out_valid_q     <= 1'b0;
            flush_pending_q <= 1'b0;
        end else begin
            cnt_q           <= cnt_d;
            acc_q           <= acc_d;
            out_data_q      <= out_data_d;
            out_bytes_q     <= out_bytes_d;
            out_valid_q     <= out_valid_d;
            flush_pending_q <= flush_pending_d;
        end
    end

    assign bus.fifo_rinc = pop;
    assign bus.out_data  = out_data_q;
    assign bus.out_bytes = out_bytes_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = (cnt_q != '0) || out_valid_q || flush_pending_q;
endmodule

// File: tb/tb_afifo_rd_packer.sv
// tb_afifo_rd_packer: directed vector table, corner sequences and randomized scoreboard check
module tb_afifo_rd_packer;
    localparam int DSIZE = 8;
    localparam int PACK  = 4;

    logic rclk;
    logic rrst;
    int   checks;
    int   errors;

    afifo_rd_packer_if #(.DSIZE(DSIZE), .PACK(PACK)) ifc ();
    afifo_rd_packer #(.DSIZE(DSIZE), .PACK(PACK)) dut (.rclk(rclk), .rrst(rrst), .bus(ifc.master));

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    typedef struct {
        logic        pv;
        logic [7:0]  pd;
        logic        fl;
        logic        rdy;
        logic        e_rinc;
        logic        e_valid;
        logic [31:0] e_data;
        logic [2:0]  e_bytes;
        logic        e_busy;
    } vec_t;

    logic [7:0]  fq[$];
    logic [7:0]  m_part[$];
    logic [31:0] m_word;
    logic [2:0]  m_bytes;
    logic        m_valid;
    logic        m_fp;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic emit();
        m_word = '0;
        foreach (m_part[i]) m_word[i*8 +: 8] = m_part[i];
        m_bytes = 3'(m_part.size());
        m_valid = 1'b1;
        m_part.delete();
    endtask

    task automatic step(input logic pv, input logic [7:0] pd, input logic fl, input logic rdy,
                        input logic rst, output logic rinc_o);
        logic m_rinc, dut_pop, can_load, fp0;
        logic [7:0] rd;
        if (pv) fq.push_back(pd);
        rrst            = rst;
        ifc.flush       = fl;
        ifc.out_ready   = rdy;
        ifc.fifo_rempty = (fq.size() == 0);
        ifc.fifo_rdata  = (fq.size() != 0) ? fq[0] : 8'($urandom);
        #1;
        can_load = !m_valid || rdy;
        m_rinc   = !rst && fq.size() != 0 && !m_fp && (m_part.size() != PACK - 1 || can_load);
        chk("rinc", 32'(ifc.fifo_rinc), 32'(m_rinc));
        chk("rinc_while_empty", 32'(ifc.fifo_rinc && ifc.fifo_rempty), 32'(0));
        rinc_o  = ifc.fifo_rinc;
        dut_pop = ifc.fifo_rinc && !ifc.fifo_rempty;
        rd      = ifc.fifo_rdata;
        @(posedge rclk);
        if (dut_pop) void'(fq.pop_front());
        fp0 = m_fp;
        if (rst) begin
            m_part.delete();
            m_word = '0; m_bytes = '0; m_valid = 1'b0; m_fp = 1'b0;
        end else begin
            if (m_valid && rdy) m_valid = 1'b0;
            if (fp0) begin
                if (can_load) begin
                    emit();
                    m_fp = 1'b0;
                end
            end else if (m_rinc) begin
                m_part.push_back(rd);
                if (m_part.size() == PACK) emit();
            end
            if (fl && !fp0) m_fp = (m_part.size() != 0);
        end
        #1;
        chk("out_valid", 32'(ifc.out_valid), 32'(m_valid));
        chk("busy", 32'(ifc.busy), 32'(m_part.size() != 0 || m_valid || m_fp));
        if (m_valid || rst) begin
            chk("out_data", ifc.out_data, m_word);
            chk("out_bytes", 32'(ifc.out_bytes), 32'(m_bytes));
        end
    endtask

    vec_t        tab[$];
    logic [31:0] words[$];
    logic [31:0] stream_exp[4];
    logic        r;

    initial begin
        checks = 0;
        errors = 0;
        m_word = '0; m_bytes = '0; m_valid = 1'b0; m_fp = 1'b0;
        rrst = 1'b1;
        ifc.flush = 1'b0; ifc.out_ready = 1'b0; ifc.fifo_rempty = 1'b1; ifc.fifo_rdata = '0;

        // basic pack
        tab.push_back('{1, 8'h11, 0, 1, 1, 0, 32'h0, 3'd0, 1});
        tab.push_back('{1, 8'h22, 0, 1, 1, 0, 32'h0, 3'd0, 1});
        tab.push_back('{1, 8'h33, 0, 1, 1, 0, 32'h0, 3'd0, 1});
        tab.push_back('{1, 8'h44, 0, 1, 1, 1, 32'h44332211, 3'd4, 1});
        tab.push_back('{0, 8'h00, 0, 1, 0, 0, 32'h0, 3'd0, 0});
        // backpressure
        tab.push_back('{1, 8'h11, 0, 0, 1, 0, 32'h0, 3'd0, 1});
        tab.push_back('{1, 8'h22, 0, 0, 1, 0, 32'h0, 3'd0, 1});
        tab.push_back('{1, 8'h33, 0, 0, 1, 0, 32'h0, 3'd0, 1});
        tab.push_back('{1, 8'h44, 0, 0, 1, 1, 32'h44332211, 3'd4, 1});
        tab.push_back('{1, 8'h55, 0, 0, 1, 1, 32'h44332211, 3'd4, 1});
        tab.push_back('{1, 8'h66, 0, 0, 1, 1, 32'h44332211, 3'd4, 1});
        tab.push_back('{1, 8'h77, 0, 0, 1, 1, 32'h44332211, 3'd4, 1});
        tab.push_back('{1, 8'h88, 0, 0, 0, 1, 32'h44332211, 3'd4, 1});
        tab.push_back('{0, 8'h00, 0, 1, 1, 1, 32'h88776655, 3'd4, 1});
        tab.push_back('{0, 8'h00, 0, 1, 0, 0, 32'h0, 3'd0, 0});
        // partial flush
        tab.push_back('{1, 8'hAA, 0, 1, 1, 0, 32'h0, 3'd0, 1});
        tab.push_back('{1, 8'hBB, 0, 1, 1, 0, 32'h0, 3'd0, 1});
        tab.push_back('{1, 8'hCC, 0, 1, 1, 0, 32'h0, 3'd0, 1});
        tab.push_back('{0, 8'h00, 1, 1, 0, 0, 32'h0, 3'd0, 1});
        tab.push_back('{0, 8'h00, 0, 1, 0, 1, 32'h00CCBBAA, 3'd3, 1});
        tab.push_back('{0, 8'h00, 0, 1, 0, 0, 32'h0, 3'd0, 0});
        // flush with nothing held
        tab.push_back('{0, 8'h00, 1, 1, 0, 0, 32'h0, 3'd0, 0});
        tab.push_back('{0, 8'h00, 0, 1, 0, 0, 32'h0, 3'd0, 0});
        // flush on the completing pop
        tab.push_back('{1, 8'h11, 0, 1, 1, 0, 32'h0, 3'd0, 1});
        tab.push_back('{1, 8'h22, 0, 1, 1, 0, 32'h0, 3'd0, 1});
        tab.push_back('{1, 8'h33, 0, 1, 1, 0, 32'h0, 3'd0, 1});
        tab.push_back('{1, 8'h44, 1, 1, 1, 1, 32'h44332211, 3'd4, 1});
        tab.push_back('{0, 8'h00, 0, 1, 0, 0, 32'h0, 3'd0, 0});
        tab.push_back('{0, 8'h00, 0, 1, 0, 0, 32'h0, 3'd0, 0});

        step(0, 8'h00, 0, 0, 1, r);
        step(0, 8'h00, 0, 0, 1, r);
        chk("rst_valid", 32'(ifc.out_valid), 32'(0));
        chk("rst_data", ifc.out_data, 32'h0);
        chk("rst_bytes", 32'(ifc.out_bytes), 32'(0));
        chk("rst_busy", 32'(ifc.busy), 32'(0));

        foreach (tab[i]) begin
            step(tab[i].pv, tab[i].pd, tab[i].fl, tab[i].rdy, 1'b0, r);
            chk($sformatf("vec%0d_rinc", i), 32'(r), 32'(tab[i].e_rinc));
            chk($sformatf("vec%0d_valid", i), 32'(ifc.out_valid), 32'(tab[i].e_valid));
            chk($sformatf("vec%0d_busy", i), 32'(ifc.busy), 32'(tab[i].e_busy));
            if (tab[i].e_valid) begin
                chk($sformatf("vec%0d_data", i), ifc.out_data, tab[i].e_data);
                chk($sformatf("vec%0d_bytes", i), 32'(ifc.out_bytes), 32'(tab[i].e_bytes));
            end
        end

        // reset mid-word
        step(1, 8'h01, 0, 1, 0, r);
        step(1, 8'h02, 0, 1, 0, r);
        fq.push_back(8'h10); fq.push_back(8'h20); fq.push_back(8'h30); fq.push_back(8'h40);
        step(0, 8'h00, 0, 1, 1, r);
        chk("rstmid_rinc", 32'(r), 32'(0));
        chk("rstmid_valid", 32'(ifc.out_valid), 32'(0));
        chk("rstmid_data", ifc.out_data, 32'h0);
        chk("rstmid_busy", 32'(ifc.busy), 32'(0));
        for (int i = 0; i < 4; i++) step(0, 8'h00, 0, 1, 0, r);
        chk("rstmid_word_valid", 32'(ifc.out_valid), 32'(1));
        chk("rstmid_word", ifc.out_data, 32'h40302010);

        // streaming 16 entries
        step(0, 8'h00, 0, 1, 1, r);
        for (int i = 0; i < 16; i++) fq.push_back(8'(i));
        for (int i = 0; i < 20; i++) begin
            step(0, 8'h00, 0, 1, 0, r);
            if (ifc.out_valid) words.push_back(ifc.out_data);
        end
        stream_exp[0] = 32'h03020100; stream_exp[1] = 32'h07060504;
        stream_exp[2] = 32'h0B0A0908; stream_exp[3] = 32'h0F0E0D0C;
        chk("stream_count", 32'(words.size()), 32'(4));
        foreach (stream_exp[i])
            chk($sformatf("stream_word%0d", i), (i < words.size()) ? words[i] : 32'hDEAD_BEEF, stream_exp[i]);

        // randomized traffic against the scoreboard
        for (int i = 0; i < 4000; i++) begin
            int pw;
            pw = (i < 2000) ? 3 : 1;
            step($urandom_range(0, 3) < pw, 8'($urandom), $urandom_range(0, 7) == 0,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 299) == 0, r);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
